// File: rtl/mem_proc_pkg.sv
// Shared definitions for memProcessing and its downstream result drain.
package mem_proc_pkg;

    localparam int DEF_NAWIDTH = 2;
    localparam int DEF_NDWIDTH = 8;

    typedef enum logic [1:0] {
        COLLECT = 2'b00,
        DRAIN   = 2'b01,
        DONE    = 2'b10
    } state_e;

endpackage

// File: rtl/mem.sv
// Single-port result RAM: synchronous write, registered read (1-cycle latency).
module mem
    import mem_proc_pkg::*;
#(
    parameter int Nawidth = DEF_NAWIDTH,
    parameter int Ndwidth = DEF_NDWIDTH
) (
    input  logic               clock,
    input  logic               we,
    input  logic [Nawidth-1:0] addr,
    input  logic [Ndwidth-1:0] din,
    output logic [Ndwidth-1:0] dout
);

    logic [Ndwidth-1:0] ram_q [2**Nawidth];

    always_ff @(posedge clock) begin
        if (we) begin
            ram_q[addr] <= din;
        end
        dout <= ram_q[addr];
    end

endmodule

// File: rtl/mem_result_drain.sv
// Snoops the result-memory writes, then on src_done streams the results out
// over valid/ready in address order with a running checksum.
module mem_result_drain
    import mem_proc_pkg::*;
#(
    parameter int Nawidth = DEF_NAWIDTH,
    parameter int Ndwidth = DEF_NDWIDTH
) (
    input  logic                       clock,
    input  logic                       Reset,
    input  logic                       Init,
    input  logic                       wr_en,
    input  logic [Nawidth-1:0]         wr_addr,
    input  logic [Ndwidth-1:0]         wr_data,
    input  logic                       src_done,
    output logic [Ndwidth-1:0]         out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic [Ndwidth+Nawidth-1:0] checksum,
    output logic                       drained,
    output logic                       wr_err,
    output logic [1:0]                 state_dbg
);

    // Handshake: a word moves on any edge where out_valid & out_ready are both
    // high; while out_valid is high and out_ready is low, out_data/out_last hold.
    localparam int                 DEPTH     = 2**Nawidth;
    localparam int                 CW        = Ndwidth + Nawidth;
    localparam logic [Nawidth-1:0] LAST_ADDR = Nawidth'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [Nawidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0]   written_q, written_d;
    logic               out_valid_q, out_valid_d;
    logic               rd_written_q, rd_written_d;
    logic [CW-1:0]      checksum_q, checksum_d;
    logic               wr_err_q, wr_err_d;

    logic               restart;
    logic               xfer;
    logic               ram_we;
    logic [Nawidth-1:0] rd_addr;
    logic [Nawidth-1:0] ram_addr;
    logic [Ndwidth-1:0] ram_q;

    mem #(
        .Nawidth (Nawidth),
        .Ndwidth (Ndwidth)
    ) u_mem (
        .clock (clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .din   (wr_data),
        .dout  (ram_q)
    );

    // Look-ahead read address keeps one word per cycle when the consumer is ready.
    always_comb begin
        restart      = Reset | Init;
        xfer         = out_valid_q & out_ready;
        rd_addr      = rd_ptr_q + Nawidth'(xfer);
        ram_we       = wr_en && (state_q == COLLECT);
        ram_addr     = (state_q == COLLECT) ? wr_addr : rd_addr;
        rd_written_d = written_q[ram_addr];
        out_data     = rd_written_q ? ram_q : '0;
    end

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        written_d   = written_q;
        out_valid_d = 1'b0;
        checksum_d  = checksum_q;
        wr_err_d    = wr_err_q;
        case (state_q)
            COLLECT: begin
                if (wr_en) begin
                    written_d[wr_addr] = 1'b1;
                end
                if (src_done) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (wr_en) begin
                    wr_err_d = 1'b1;
                end
                out_valid_d = 1'b1;
                if (xfer) begin
                    rd_ptr_d   = rd_addr;
                    checksum_d = checksum_q + CW'(out_data);
                    if (rd_ptr_q == LAST_ADDR) begin
                        state_d     = DONE;
                        out_valid_d = 1'b0;
                    end
                end
            end
            DONE: begin
                if (wr_en) begin
                    wr_err_d = 1'b1;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // RAM contents survive a restart; clearing the written mask hides them.
    always_ff @(posedge clock) begin
        if (restart) begin
            state_q      <= COLLECT;
            rd_ptr_q     <= '0;
            written_q    <= '0;
            out_valid_q  <= 1'b0;
            rd_written_q <= 1'b0;
            checksum_q   <= '0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            written_q    <= written_d;
            out_valid_q  <= out_valid_d;
            rd_written_q <= rd_written_d;
            checksum_q   <= checksum_d;
            wr_err_q     <= wr_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_valid_q & (rd_ptr_q == LAST_ADDR);
    assign checksum  = checksum_q;
    assign drained   = (state_q == DONE);
    assign wr_err    = wr_err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_result_drain.sv
// Directed bench for mem_result_drain: queue-based stream model checked every
// cycle, plus hand-computed stream/checksum/latency expectations per scenario.
module tb_mem_result_drain;

    logic       clock = 1'b0;
    logic       Reset, Init, wr_en, src_done, out_ready;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] out_data;
    logic       out_valid, out_last, drained, wr_err;
    logic [9:0] checksum;
    logic [1:0] state_dbg;

    int vectors     = 0;
    int miscompares = 0;
    bit armed       = 1'b0;

    mem_result_drain dut (
        .clock     (clock),
        .Reset     (Reset),
        .Init      (Init),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .src_done  (src_done),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .checksum  (checksum),
        .drained   (drained),
        .wr_err    (wr_err),
        .state_dbg (state_dbg)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: collected words, then an expected output queue.
    logic [7:0] m_mem [4];
    bit         m_wr  [4];
    int         m_phase   = 0;   // 0 collecting, 1 draining, 2 finished
    bit         m_started = 0;
    bit         m_err     = 0;
    logic [9:0] m_sum     = '0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    bit         got_last_q[$];

    always @(negedge clock) begin
        if (armed) begin
            bit exp_v;
            check("wr_err", wr_err, m_err);
            check("drained", drained, m_phase == 2);
            check("checksum", checksum, m_sum);
            exp_v = (m_phase == 1) && m_started;
            check("out_valid", out_valid, exp_v);
            if (exp_v) begin
                check("out_data", out_data, exp_q[0]);
                check("out_last", out_last, exp_q.size() == 1);
            end else begin
                check("out_last_idle", out_last, 1'b0);
            end
            if (out_valid === 1'b1 && out_ready && !(Reset || Init)) begin
                got_q.push_back(out_data);
                got_last_q.push_back(out_last);
            end
            if (Reset || Init) begin
                m_phase = 0; m_started = 0; m_err = 0; m_sum = '0;
                exp_q.delete();
                for (int i = 0; i < 4; i++) m_wr[i] = 0;
            end else begin
                case (m_phase)
                    0: begin
                        if (wr_en) begin
                            m_mem[wr_addr] = wr_data;
                            m_wr[wr_addr]  = 1;
                        end
                        if (src_done) begin
                            exp_q.delete();
                            for (int i = 0; i < 4; i++) exp_q.push_back(m_wr[i] ? m_mem[i] : 8'h00);
                            m_phase   = 1;
                            m_started = 0;
                        end
                    end
                    1: begin
                        if (wr_en) m_err = 1;
                        if (!m_started) m_started = 1;
                        else if (out_ready && exp_q.size() > 0) begin
                            m_sum = m_sum + 10'(exp_q.pop_front());
                            if (exp_q.size() == 0) m_phase = 2;
                        end
                    end
                    default: begin
                        if (wr_en) m_err = 1;
                    end
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic restart(input logic r, input logic i);
        Reset = r; Init = i;
        step();
        Reset = 1'b0; Init = 1'b0;
        got_q.delete();
        got_last_q.delete();
    endtask

    task automatic write(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic load4(input logic [7:0] d0, d1, d2, d3);
        write(2'd0, d0); write(2'd1, d1); write(2'd2, d2); write(2'd3, d3);
    endtask

    task automatic start();
        src_done = 1'b1;
        step();
        src_done = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (drained === 1'b1) break;
        end
        check({name, "_drained"}, drained, 1'b1);
    endtask

    task automatic expect_stream(input string name, input logic [7:0] e0, e1, e2, e3);
        logic [7:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        check({name, "_count"}, got_q.size(), 4);
        if (got_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("%s_word%0d", name, i), got_q[i], e[i]);
                check($sformatf("%s_last%0d", name, i), got_last_q[i], i == 3);
            end
        end
    endtask

    initial begin
        logic [1:0] rst_r [3];
        logic [1:0] rst_i [3];
        bit         pat   [7];
        rst_r = '{2'd0, 2'd1, 2'd1};
        rst_i = '{2'd1, 2'd0, 2'd1};
        pat   = '{1, 0, 0, 1, 0, 1, 1};
        Reset = 1'b1; Init = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        src_done = 1'b0; out_ready = 1'b1;
        step();
        step();
        Reset = 1'b0;
        armed = 1'b1;
        @(negedge clock);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_checksum", checksum, 10'h000);
        check("rst_drained", drained, 1'b0);
        check("rst_wr_err", wr_err, 1'b0);
        check("rst_state", state_dbg, 2'b00);

        // Full-throughput drain
        restart(1'b1, 1'b0);
        load4(8'h10, 8'h20, 8'h30, 8'h40);
        start();
        wait_drained("t1");
        expect_stream("t1", 8'h10, 8'h20, 8'h30, 8'h40);
        check("t1_checksum", checksum, 10'h0A0);
        check("t1_valid_after", out_valid, 1'b0);
        check("t1_state", state_dbg, 2'b10);

        // Back-pressure pattern
        restart(1'b1, 1'b0);
        load4(8'h10, 8'h20, 8'h30, 8'h40);
        start();
        step();
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i];
            step();
        end
        out_ready = 1'b1;
        wait_drained("t2");
        expect_stream("t2", 8'h10, 8'h20, 8'h30, 8'h40);
        check("t2_checksum", checksum, 10'h0A0);

        // Stale RAM contents masked
        restart(1'b0, 1'b1);
        write(2'd1, 8'h55);
        start();
        wait_drained("t3");
        expect_stream("t3", 8'h00, 8'h55, 8'h00, 8'h00);
        check("t3_checksum", checksum, 10'h055);

        // No wrap, write during drain flagged and dropped
        restart(1'b1, 1'b0);
        load4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        start();
        step();
        write(2'd2, 8'h12);
        wait_drained("t4");
        expect_stream("t4", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        check("t4_checksum", checksum, 10'h3FC);
        check("t4_wr_err", wr_err, 1'b1);

        // Restart mid-drain: Init, Reset, both
        for (int k = 0; k < 3; k++) begin
            restart(1'b1, 1'b0);
            load4(8'h10, 8'h20, 8'h30, 8'h40);
            start();
            step();
            step();
            step();
            Reset = rst_r[k][0]; Init = rst_i[k][0];
            @(negedge clock);
            check($sformatf("t5_%0d_partial_sum", k), checksum, 10'h030);
            step();
            Reset = 1'b0; Init = 1'b0;
            @(negedge clock);
            check($sformatf("t5_%0d_valid", k), out_valid, 1'b0);
            check($sformatf("t5_%0d_checksum", k), checksum, 10'h000);
            check($sformatf("t5_%0d_state", k), state_dbg, 2'b00);
            got_q.delete();
            got_last_q.delete();
            step();
            load4(8'h01, 8'h02, 8'h03, 8'(8'h04 + k));
            start();
            wait_drained($sformatf("t5_%0d", k));
            expect_stream($sformatf("t5_%0d", k), 8'h01, 8'h02, 8'h03, 8'(8'h04 + k));
            check($sformatf("t5_%0d_sum", k), checksum, 10'(10'h00A + k));
        end

        // Write coincident with src_done, and start-up latency
        restart(1'b1, 1'b0);
        write(2'd0, 8'hA1); write(2'd1, 8'hB2); write(2'd2, 8'hC3);
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h77; src_done = 1'b1;
        step();
        wr_en = 1'b0; src_done = 1'b0;
        @(negedge clock);
        check("t6_lat_cycle1", out_valid, 1'b0);
        step();
        @(negedge clock);
        check("t6_lat_cycle2", out_valid, 1'b1);
        wait_drained("t6");
        expect_stream("t6", 8'hA1, 8'hB2, 8'hC3, 8'h77);
        check("t6_checksum", checksum, 10'h28D);
        check("t6_wr_err", wr_err, 1'b0);

        step();
        armed = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
